// File: rtl/sr_latch_pkg.sv
// Shared constants and helpers for the clocked SR latch: conflict-policy
// encodings and the per-bit request decode.
package sr_latch_pkg;

  localparam int MODE_HOLD    = 0;
  localparam int MODE_SET_DOM = 1;
  localparam int MODE_RST_DOM = 2;

  // Request encoding is {S, R} so a bit pair casts directly onto it.
  typedef enum logic [1:0] {
    SR_HOLD = 2'b00,
    SR_CLR  = 2'b01,
    SR_SET  = 2'b10,
    SR_BOTH = 2'b11
  } sr_req_e;

  // Any encoding outside the defined policies falls back to hold.
  function automatic int norm_mode(input int mode);
    if (mode == MODE_SET_DOM || mode == MODE_RST_DOM) begin
      return mode;
    end
    return MODE_HOLD;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR bit: purely combinational next-state and conflict decode.
// The owning top level holds the register, so S/R never reach outputs directly.
module sr_cell
  import sr_latch_pkg::*;
#(
  parameter int CONFLICT_MODE = 0
) (
  input  logic s,
  input  logic r,
  input  logic q,
  output logic q_next,
  output logic conflict
);

  localparam int EFF_MODE = norm_mode(CONFLICT_MODE);

  sr_req_e req;

  always_comb begin
    req      = sr_req_e'({s, r});
    q_next   = q;
    conflict = 1'b0;
    unique case (req)
      SR_HOLD: q_next = q;
      SR_CLR:  q_next = 1'b0;
      SR_SET:  q_next = 1'b1;
      SR_BOTH: begin
        conflict = 1'b1;
        if (EFF_MODE == MODE_SET_DOM) begin
          q_next = 1'b1;
        end else if (EFF_MODE == MODE_RST_DOM) begin
          q_next = 1'b0;
        end
      end
    endcase
  end

endmodule

// File: rtl/sr_latch.sv
// WIDTH independent clocked SR bits with a selectable S=R=1 policy,
// registered state and conflict flags, and derived Qn / conflict_any.
module sr_latch
  import sr_latch_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int CONFLICT_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] conflict_q;
  logic [WIDTH-1:0] conflict_d;
  logic [WIDTH-1:0] cell_q_next;
  logic [WIDTH-1:0] cell_conflict;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .CONFLICT_MODE(CONFLICT_MODE)
    ) u_cell (
      .s       (S[i]),
      .r       (R[i]),
      .q       (q_q[i]),
      .q_next  (cell_q_next[i]),
      .conflict(cell_conflict[i])
    );
  end

  always_comb begin
    q_d        = cell_q_next;
    conflict_d = cell_conflict;
  end

  // Reset wins over every S/R combination and never flags a conflict.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= '0;
      conflict_q <= '0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign Q            = q_q;
  assign Qn           = ~q_q;
  assign conflict     = conflict_q;
  assign conflict_any = |conflict_q;

endmodule

// File: tb/tb_sr_latch.sv
// Bench for sr_latch: four WIDTH=4 instances (modes 0..3, 3 = unsupported)
// plus one WIDTH=1 mode-0 instance, checked against a scoreboard of expected states.
module tb_sr_latch;

  logic       clk;
  logic       rst;
  logic [3:0] s_in;
  logic [3:0] r_in;

  logic [3:0] q_m   [4];
  logic [3:0] qn_m  [4];
  logic [3:0] c_m   [4];
  logic       any_m [4];

  logic w1_q, w1_qn, w1_c, w1_any;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    sr_latch #(
      .WIDTH(4),
      .CONFLICT_MODE(m)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .S           (s_in),
      .R           (r_in),
      .Q           (q_m[m]),
      .Qn          (qn_m[m]),
      .conflict    (c_m[m]),
      .conflict_any(any_m[m])
    );
  end

  sr_latch #(
    .WIDTH(1),
    .CONFLICT_MODE(0)
  ) u_dut_w1 (
    .clk         (clk),
    .rst         (rst),
    .S           (s_in[0:0]),
    .R           (r_in[0:0]),
    .Q           (w1_q),
    .Qn          (w1_qn),
    .conflict    (w1_c),
    .conflict_any(w1_any)
  );

  // Clock and reset-state drivers
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {q0,c0,q1,c1,q2,c2,q3,c3,w1_q,w1_c}
  logic [33:0] exp_q[$];
  logic [33:0] exp_v;
  logic [33:0] last_exp;
  logic [3:0]  mq [4];
  logic [3:0]  mc [4];
  int          n_checks;
  int          n_fail;

  function automatic logic [33:0] obs();
    return {q_m[0], c_m[0], q_m[1], c_m[1], q_m[2], c_m[2], q_m[3], c_m[3], w1_q, w1_c};
  endfunction

  // Reference truth table for one bit: returns {q_next, conflict}.
  function automatic logic [1:0] ref_bit(input int mode, input logic q, input logic s,
                                         input logic r, input logic rs);
    if (rs) return 2'b00;
    if (s && r) begin
      if (mode == 1) return 2'b11;
      if (mode == 2) return 2'b01;
      return {q, 1'b1};
    end
    if (s) return 2'b10;
    if (r) return 2'b00;
    return {q, 1'b0};
  endfunction

  // Driver: apply inputs at negedge, push expected state, return just after the edge.
  task automatic step(input logic [3:0] s, input logic [3:0] r, input logic rs);
    logic [1:0] nb;
    @(negedge clk);
    s_in = s;
    r_in = r;
    rst  = rs;
    for (int m = 0; m < 4; m++) begin
      for (int b = 0; b < 4; b++) begin
        nb = ref_bit(m, mq[m][b], s[b], r[b], rs);
        mq[m][b] = nb[1];
        mc[m][b] = nb[0];
      end
    end
    last_exp = {mq[0], mc[0], mq[1], mc[1], mq[2], mc[2], mq[3], mc[3], mq[0][0], mc[0][0]};
    exp_q.push_back(last_exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(4'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_edge: got %h expected %h", obs(), exp_v);
    end
    step(4'h0, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL reset_idle: got %h expected %h", obs(), exp_v);
    end
    n_checks++;
    if ({w1_q, w1_qn, w1_c, w1_any} !== 4'b0100) begin
      n_fail++;
      $display("FAIL reset_w1_outputs: got %b expected 0100", {w1_q, w1_qn, w1_c, w1_any});
    end
    n_checks++;
    if (qn_m[0] !== ~mq[0]) begin
      n_fail++;
      $display("FAIL reset_qn: got %b expected %b", qn_m[0], ~mq[0]);
    end
  endtask

  task automatic test_set_hold();
    step(4'hF, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL set: got %h expected %h", obs(), exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      step(4'h0, 4'h0, 1'b0);
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs() !== exp_v || w1_q !== 1'b1) begin
        n_fail++;
        $display("FAIL set_hold_%0d: got %h expected %h", i, obs(), exp_v);
      end
    end
  endtask

  task automatic test_clear();
    step(4'h0, 4'hF, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL clear: got %h expected %h", obs(), exp_v);
    end
    n_checks++;
    if ({w1_q, w1_qn} !== 2'b01) begin
      n_fail++;
      $display("FAIL clear_w1_qn: got %b expected 01", {w1_q, w1_qn});
    end
  endtask

  task automatic test_conflict_modes();
    step(4'hF, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL conflict_preset: got %h expected %h", obs(), exp_v);
    end
    step(4'hF, 4'hF, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL conflict_both: got %h expected %h", obs(), exp_v);
    end
    n_checks++;
    if ({q_m[0], q_m[1], q_m[2], q_m[3]} !== 16'hFF0F) begin
      n_fail++;
      $display("FAIL conflict_mode_q: got %h expected ff0f", {q_m[0], q_m[1], q_m[2], q_m[3]});
    end
    n_checks++;
    if ({any_m[0], any_m[1], any_m[2], any_m[3], w1_any} !== 5'b11111) begin
      n_fail++;
      $display("FAIL conflict_any_set: got %b expected 11111",
               {any_m[0], any_m[1], any_m[2], any_m[3], w1_any});
    end
    n_checks++;
    if (qn_m[2] !== ~mq[2]) begin
      n_fail++;
      $display("FAIL conflict_qn_m2: got %b expected %b", qn_m[2], ~mq[2]);
    end
    step(4'h0, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL conflict_clear: got %h expected %h", obs(), exp_v);
    end
    n_checks++;
    if ({any_m[0], any_m[1], any_m[2], any_m[3], w1_any} !== 5'b00000) begin
      n_fail++;
      $display("FAIL conflict_any_clear: got %b expected 00000",
               {any_m[0], any_m[1], any_m[2], any_m[3], w1_any});
    end
  endtask

  task automatic test_glitch();
    step(4'h0, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL glitch_pre: got %h expected %h", obs(), exp_v);
    end
    // Pulse S fully between two edges; it must never be sampled.
    #1 s_in = 4'hF;
    #1 s_in = 4'h0;
    n_checks++;
    if (obs() !== last_exp) begin
      n_fail++;
      $display("FAIL glitch_midcycle: got %h expected %h", obs(), last_exp);
    end
    step(4'h0, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL glitch_post: got %h expected %h", obs(), exp_v);
    end
  endtask

  task automatic test_reset_priority();
    step(4'hF, 4'h0, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL rstpri_preset: got %h expected %h", obs(), exp_v);
    end
    step(4'hF, 4'hF, 1'b1);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v || {w1_q, w1_c} !== 2'b00) begin
      n_fail++;
      $display("FAIL rstpri_both: got %h expected %h", obs(), exp_v);
    end
    step(4'h0, 4'hF, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL rstpri_resume: got %h expected %h", obs(), exp_v);
    end
  endtask

  task automatic test_mixed_width();
    step(4'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL mixed_reset: got %h expected %h", obs(), exp_v);
    end
    step(4'b1010, 4'b0110, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (obs() !== exp_v) begin
      n_fail++;
      $display("FAIL mixed_model: got %h expected %h", obs(), exp_v);
    end
    n_checks++;
    if ({q_m[0], c_m[0]} !== 8'b1000_0010) begin
      n_fail++;
      $display("FAIL mixed_mode0: got %b expected 10000010", {q_m[0], c_m[0]});
    end
    n_checks++;
    if ({q_m[1], q_m[2]} !== 8'b1010_1000) begin
      n_fail++;
      $display("FAIL mixed_mode12: got %b expected 10101000", {q_m[1], q_m[2]});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] s, r;
    for (int i = 0; i < 60; i++) begin
      s = 4'($urandom_range(0, 15));
      r = 4'($urandom_range(0, 15));
      step(s, r, ($urandom_range(0, 15) == 0));
      exp_v = exp_q.pop_front();
      n_checks++;
      if (obs() !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: got %h expected %h (s=%b r=%b)", i, obs(), exp_v, s, r);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s_in     = 4'h0;
    r_in     = 4'h0;
    for (int m = 0; m < 4; m++) begin
      mq[m] = 4'h0;
      mc[m] = 4'h0;
    end
    last_exp = '0;
    test_reset();
    test_set_hold();
    test_clear();
    test_conflict_modes();
    test_glitch();
    test_reset_priority();
    test_mixed_width();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
